// File: rtl/ifft_4point_sdf.sv
// Streaming 4-point radix-2 SDF inverse FFT, decimation in time.
// Bins arrive bit-reversed (X0,X2,X1,X3); samples leave in natural order.
module ifft_4point_sdf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  output logic         out_sof,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         frame_err
);

  // (a+b)/2 with floor, computed one bit wider so it never wraps
  function automatic logic [W-1:0] half_add(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    return s[W:1];
  endfunction

  // (a-b)/2 with floor; the extra bit absorbs -(-2^(W-1))
  function automatic logic [W-1:0] half_sub(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0] s;
    s = {a[W-1], a} - {b[W-1], b};
    return s[W:1];
  endfunction

  logic [1:0]   ph;
  logic [1:0]   ph1;
  logic [1:0]   ph2;
  logic         sync;

  logic [W-1:0] x_re;
  logic [W-1:0] x_im;

  logic [W-1:0] d1_re;
  logic [W-1:0] d1_im;
  logic [W-1:0] d1n_re;
  logic [W-1:0] d1n_im;
  logic [W-1:0] s1_re;
  logic [W-1:0] s1_im;

  logic [W-1:0] d2a_re;
  logic [W-1:0] d2a_im;
  logic [W-1:0] d2b_re;
  logic [W-1:0] d2b_im;
  logic [W-1:0] d2n_re;
  logic [W-1:0] d2n_im;
  logic [W-1:0] y_re;
  logic [W-1:0] y_im;

  logic [2:0]   v_pipe;
  logic [2:0]   s_pipe;

  // A valid sof always lands on phase 0; stage 2 trails by one
  assign sync = in_valid & in_sof;
  assign ph1  = sync ? 2'd0 : ph;
  assign ph2  = ph1 - 2'd1;

  // Idle cycles feed zeros through the delay lines
  assign x_re = in_valid ? in_re : '0;
  assign x_im = in_valid ? in_im : '0;

  // Phase counter, resynchronised by a valid sof
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      ph        <= 2'd0;
      frame_err <= 1'b0;
    end else begin
      ph        <= ph1 + 2'd1;
      frame_err <= sync && (ph != 2'd0);
    end
  end

  // Stage 1 butterfly: even phases load, odd phases combine
  always_comb begin
    s1_re  = d1_re;
    s1_im  = d1_im;
    d1n_re = x_re;
    d1n_im = x_im;
    if (ph1[0]) begin
      s1_re  = half_add(d1_re, x_re);
      s1_im  = half_add(d1_im, x_im);
      d1n_re = half_sub(d1_re, x_re);
      d1n_im = half_sub(d1_im, x_im);
    end
  end

  // Stage 1 one-deep feedback delay
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      d1_re <= '0;
      d1_im <= '0;
    end else begin
      d1_re <= d1n_re;
      d1_im <= d1n_im;
    end
  end

  // Stage 2 butterfly; phase 3 sees b1 and folds in the +j rotation
  always_comb begin
    y_re   = d2b_re;
    y_im   = d2b_im;
    d2n_re = s1_re;
    d2n_im = s1_im;
    unique case (1'b1)
      (ph2 == 2'd2): begin
        y_re   = half_add(d2b_re, s1_re);
        y_im   = half_add(d2b_im, s1_im);
        d2n_re = half_sub(d2b_re, s1_re);
        d2n_im = half_sub(d2b_im, s1_im);
      end
      (ph2 == 2'd3): begin
        y_re   = half_sub(d2b_re, s1_im);
        y_im   = half_add(d2b_im, s1_re);
        d2n_re = half_add(d2b_re, s1_im);
        d2n_im = half_sub(d2b_im, s1_re);
      end
      default: begin
        y_re = d2b_re;
        y_im = d2b_im;
      end
    endcase
  end

  // Stage 2 two-deep feedback delay, oldest entry in d2b
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      d2a_re <= '0;
      d2a_im <= '0;
      d2b_re <= '0;
      d2b_im <= '0;
    end else begin
      d2a_re <= d2n_re;
      d2a_im <= d2n_im;
      d2b_re <= d2a_re;
      d2b_im <= d2a_im;
    end
  end

  // Valid/sof tags ride alongside the data
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      v_pipe <= '0;
      s_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[1:0], in_valid};
      s_pipe <= {s_pipe[1:0], sync};
    end
  end

  // Registered outputs, forced to zero on invalid slots
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= v_pipe[2];
      out_sof   <= s_pipe[2];
      out_re    <= v_pipe[2] ? y_re : '0;
      out_im    <= v_pipe[2] ? y_im : '0;
    end
  end

endmodule

// File: tb/tb_ifft_4point_sdf.sv
// Scoreboard bench for the 4-point SDF IFFT.
// Driver queues expected samples; a monitor checks them as they emerge.
module tb_ifft_4point_sdf;

  typedef int q4_t[4];

  typedef struct {
    int cyc;
    int re;
    int im;
    bit sof;
    bit dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       clear;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_re;
  logic [7:0] in_im;
  logic       out_valid;
  logic       out_sof;
  logic [7:0] out_re;
  logic [7:0] out_im;
  logic       frame_err;

  exp_t q[$];
  int   eq[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  ifft_4point_sdf #(.W(8)) dut (
    .clk(clk),
    .clear(clear),
    .in_valid(in_valid),
    .in_sof(in_sof),
    .in_re(in_re),
    .in_im(in_im),
    .out_valid(out_valid),
    .out_sof(out_sof),
    .out_re(out_re),
    .out_im(out_im),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               n, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queue
  always @(negedge clk) begin
    if (clear) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_time", cyc, e.cyc);
          chk("out_sof", int'(out_sof), int'(e.sof));
          if (e.dat) begin
            chk("out_re", int'($signed(out_re)), e.re);
            chk("out_im", int'($signed(out_im)), e.im);
          end
        end
      end else begin
        chk("idle_zero", int'({out_sof, out_re, out_im}), 0);
      end
      if (frame_err) begin
        if (eq.size() == 0) chk("unexpected_err", 1, 0);
        else chk("err_time", cyc, eq.pop_front());
      end
    end
  end

  task automatic drive(input int re, input int im,
                       input bit v, input bit s);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_re    = 8'(re);
    in_im    = 8'(im);
  endtask

  task automatic idle(input int n);
    repeat (4 * n) drive(0, 0, 1'b0, 1'b0);
  endtask

  // Reference IDFT on bit-reversed input, halving after each stage
  task automatic model(input q4_t r, input q4_t i,
                       output q4_t er, output q4_t ei);
    int a0r, a0i, a1r, a1i, b0r, b0i, b1r, b1i;
    a0r = (r[0] + r[1]) >>> 1;
    a0i = (i[0] + i[1]) >>> 1;
    a1r = (r[0] - r[1]) >>> 1;
    a1i = (i[0] - i[1]) >>> 1;
    b0r = (r[2] + r[3]) >>> 1;
    b0i = (i[2] + i[3]) >>> 1;
    b1r = (r[2] - r[3]) >>> 1;
    b1i = (i[2] - i[3]) >>> 1;
    er[0] = (a0r + b0r) >>> 1;
    ei[0] = (a0i + b0i) >>> 1;
    er[1] = (a1r - b1i) >>> 1;
    ei[1] = (a1i + b1r) >>> 1;
    er[2] = (a0r - b0r) >>> 1;
    ei[2] = (a0i - b0i) >>> 1;
    er[3] = (a1r + b1i) >>> 1;
    ei[3] = (a1i - b1r) >>> 1;
  endtask

  task automatic frame(input q4_t r, input q4_t i,
                       input q4_t hr, input q4_t hi,
                       input bit use_model, input bit misal);
    q4_t er, ei;
    int  c0;
    exp_t x;
    if (use_model) model(r, i, er, ei);
    else begin
      er = hr;
      ei = hi;
    end
    drive(r[0], i[0], 1'b1, 1'b1);
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      x.cyc = c0 + 4 + k;
      x.re  = er[k];
      x.im  = ei[k];
      x.sof = (k == 0);
      x.dat = 1'b1;
      q.push_back(x);
    end
    if (misal) eq.push_back(c0 + 1);
    for (int k = 1; k < 4; k++) drive(r[k], i[k], 1'b1, 1'b0);
  endtask

  task automatic release_clear();
    @(posedge clk);
    #1 clear = 1'b1;
  endtask

  task automatic push_tag(input int c, input bit s);
    exp_t x;
    x.cyc = c;
    x.re  = 0;
    x.im  = 0;
    x.sof = s;
    x.dat = 1'b0;
    q.push_back(x);
  endtask

  q4_t z = '{0, 0, 0, 0};
  int  pc;

  initial begin
    clear    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_re    = '0;
    in_im    = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sof", int'(out_sof), 0);
    chk("rst_data", int'({out_re, out_im}), 0);
    chk("rst_err", int'(frame_err), 0);
    release_clear();

    frame('{4, 0, 0, 0}, z, '{1, 1, 1, 1}, z, 1'b0, 1'b0);
    frame('{0, 0, 4, 0}, z, '{1, 0, -1, 0}, '{0, 1, 0, -1},
          1'b0, 1'b0);
    frame('{1, 0, 0, 0}, z, z, z, 1'b0, 1'b0);
    frame('{-128, -128, -128, -128}, '{-128, -128, -128, -128},
          '{-128, 0, 0, 0}, '{-128, 0, 0, 0}, 1'b0, 1'b0);
    idle(1);

    frame('{10, -20, 30, -40}, '{5, 7, -9, 11}, z, z, 1'b1, 1'b0);
    frame('{127, -128, 64, -1}, '{-3, 2, 1, 0}, z, z, 1'b1, 1'b0);
    frame('{-128, 127, -128, 127}, '{33, -77, 100, -5}, z, z,
          1'b1, 1'b0);
    idle(2);

    drive(5, 0, 1'b1, 1'b1);
    pc = cyc;
    push_tag(pc + 4, 1'b1);
    push_tag(pc + 5, 1'b0);
    drive(3, 0, 1'b1, 1'b0);
    frame('{0, 0, 4, 0}, z, '{1, 0, -1, 0}, '{0, 1, 0, -1},
          1'b0, 1'b1);
    frame('{9, -6, 2, 50}, '{-1, 4, -7, 3}, z, z, 1'b1, 1'b0);
    idle(2);

    frame('{4, 0, 0, 0}, z, '{1, 1, 1, 1}, z, 1'b0, 1'b0);
    drive(8, 8, 1'b1, 1'b1);
    drive(8, 8, 1'b1, 1'b0);
    drive(8, 8, 1'b1, 1'b0);
    #2 clear = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    chk("clr_valid", int'(out_valid), 0);
    chk("clr_sof", int'(out_sof), 0);
    chk("clr_data", int'({out_re, out_im}), 0);
    chk("clr_err", int'(frame_err), 0);
    repeat (2) @(negedge clk);
    q.delete();
    eq.delete();
    release_clear();
    frame('{4, 0, 0, 0}, z, '{1, 1, 1, 1}, z, 1'b0, 1'b0);
    idle(2);

    for (int k = 0; k < 40 && (q.size() + eq.size()) > 0; k++)
      @(negedge clk);
    chk("drain", q.size() + eq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
